// File: rtl/vec_inst_queue.sv
// rtl/vec_inst_queue.sv - pre-decoding circular issue queue from scalar core to vector processor.
// Optional same-cycle empty-queue bypass when VEC_IQ_BYPASS_EN is defined.
`ifndef XLEN
`define XLEN 32
`endif

module vec_inst_queue #(
  parameter int XLEN  = `XLEN,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inst_valid,
  output logic                     inst_ready,
  input  logic [XLEN-1:0]          instruction,
  input  logic [XLEN-1:0]          rs1_data,
  input  logic [XLEN-1:0]          rs2_data,
  input  logic                     flush,
  output logic                     vec_valid,
  input  logic                     vec_ready,
  output logic [XLEN-1:0]          vec_instruction,
  output logic [XLEN-1:0]          vec_rs1_data,
  output logic [XLEN-1:0]          vec_rs2_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     drop_pulse
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] r_inst_mem [DEPTH];
  logic [XLEN-1:0] r_rs1_mem  [DEPTH];
  logic [XLEN-1:0] r_rs2_mem  [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_drop;

  logic [6:0]      w_op;
  logic [2:0]      w_width;
  logic            w_is_vec;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;

  assign w_op    = instruction[6:0];
  assign w_width = instruction[14:12];

  // OP-V, or LOAD-FP/STORE-FP with a vector element-width encoding
  assign w_is_vec = (w_op == 7'b1010111) ||
                    (((w_op == 7'b0000111) || (w_op == 7'b0100111)) &&
                     ((w_width == 3'b000) || (w_width == 3'b101) ||
                      (w_width == 3'b110) || (w_width == 3'b111)));

  assign count      = r_count;
  assign full       = (r_count == (AW+1)'(DEPTH));
  assign empty      = (r_count == '0);
  assign inst_ready = !full && !flush;
  assign drop_pulse = r_drop;
  assign w_accept   = inst_valid && inst_ready;
  assign w_pop      = !empty && vec_ready && !flush;

`ifdef VEC_IQ_BYPASS_EN
  logic w_bypass;

  assign w_bypass = empty && !flush && inst_valid && w_is_vec;
  assign w_push   = w_accept && w_is_vec && !(w_bypass && vec_ready);

  always_comb begin
    vec_valid       = !empty;
    vec_instruction = r_inst_mem[r_rd_ptr];
    vec_rs1_data    = r_rs1_mem[r_rd_ptr];
    vec_rs2_data    = r_rs2_mem[r_rd_ptr];
    if (w_bypass) begin
      vec_valid       = 1'b1;
      vec_instruction = instruction;
      vec_rs1_data    = rs1_data;
      vec_rs2_data    = rs2_data;
    end
  end
`else
  assign w_push          = w_accept && w_is_vec;
  assign vec_valid       = !empty;
  assign vec_instruction = r_inst_mem[r_rd_ptr];
  assign vec_rs1_data    = r_rs1_mem[r_rd_ptr];
  assign vec_rs2_data    = r_rs2_mem[r_rd_ptr];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= w_accept && !w_is_vec;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left untouched by flush; only pointers are cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_inst_mem[i] <= '0;
        r_rs1_mem[i]  <= '0;
        r_rs2_mem[i]  <= '0;
      end
    end else if (w_push && !flush) begin
      r_inst_mem[r_wr_ptr] <= instruction;
      r_rs1_mem[r_wr_ptr]  <= rs1_data;
      r_rs2_mem[r_wr_ptr]  <= rs2_data;
    end
  end

endmodule

// File: tb/tb_vec_inst_queue.sv
// tb/tb_vec_inst_queue.sv - directed self-checking bench for vec_inst_queue (DEPTH=4, XLEN=32).
// Bypass expectations follow VEC_IQ_BYPASS_EN when defined.
`timescale 1ns/1ps

module tb_vec_inst_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        vec_valid;
  logic        vec_ready;
  logic [31:0] vec_instruction;
  logic [31:0] vec_rs1_data;
  logic [31:0] vec_rs2_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        drop_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] VADD = 32'h02008057;
  localparam logic [31:0] ADDI = 32'h00000013;
  localparam logic [31:0] FLW  = 32'h00002007;
  localparam logic [31:0] VLE  = 32'h02056007;

  vec_inst_queue #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_instruction(vec_instruction), .vec_rs1_data(vec_rs1_data), .vec_rs2_data(vec_rs2_data),
    .count(count), .full(full), .empty(empty), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1, input logic r);
    @(negedge clk);
    inst_valid  = v;
    instruction = ins;
    rs1_data    = r1;
    rs2_data    = ~r1;
    vec_ready   = r;
    #1;
  endtask

  task automatic test_reset();
    inst_valid = 0; instruction = 0; rs1_data = 0; rs2_data = 0;
    flush = 0; vec_ready = 0; reset = 0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (empty !== 1'b1 || count !== 3'd0 || vec_valid !== 1'b0 || full !== 1'b0 ||
        inst_ready !== 1'b1 || drop_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: empty=%b count=%0d vec_valid=%b full=%b inst_ready=%b drop=%b, expected 1 0 0 0 1 0",
               empty, count, vec_valid, full, inst_ready, drop_pulse);
    end
    n_tests++;
    if (vec_instruction !== 32'd0 || vec_rs1_data !== 32'd0 || vec_rs2_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: inst=%h rs1=%h rs2=%h, expected all 0",
               vec_instruction, vec_rs1_data, vec_rs2_data);
    end
    @(negedge clk);
    reset = 1;
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1, VADD, 32'h100 + i, 0);
      step();
      n_tests++;
      if (count !== 3'(i + 1)) begin
        n_fail++;
        $display("FAIL fill_count[%0d]: got %0d, expected %0d", i, count, i + 1);
      end
    end
    inst_valid = 0;
    n_tests++;
    if (full !== 1'b1 || inst_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: full=%b inst_ready=%b, expected 1 0", full, inst_ready);
    end
    drive(1, VADD, 32'h1FF, 0);
    step();
    n_tests++;
    if (count !== 3'd4) begin
      n_fail++;
      $display("FAIL fill_fifth_rejected: count=%0d, expected 4", count);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'd0, 32'd0, 1);
      n_tests++;
      if (vec_valid !== 1'b1 || vec_rs1_data !== 32'h100 + i || vec_rs2_data !== ~(32'h100 + i) ||
          vec_instruction !== VADD) begin
        n_fail++;
        $display("FAIL fill_drain[%0d]: valid=%b rs1=%h rs2=%h inst=%h, expected 1 %h %h %h",
                 i, vec_valid, vec_rs1_data, vec_rs2_data, vec_instruction,
                 32'h100 + i, ~(32'h100 + i), VADD);
      end
      step();
    end
    vec_ready = 0;
    n_tests++;
    if (empty !== 1'b1 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL fill_drained_empty: empty=%b count=%0d, expected 1 0", empty, count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive(1, VADD, 32'h10 + i, 0);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, VADD, 32'h13 + i, 1);
      n_tests++;
      if (vec_valid !== 1'b1 || vec_rs1_data !== 32'h10 + i) begin
        n_fail++;
        $display("FAIL b2b_order[%0d]: valid=%b rs1=%h, expected 1 %h", i, vec_valid, vec_rs1_data, 32'h10 + i);
      end
      step();
      n_tests++;
      if (count !== 3'd3) begin
        n_fail++;
        $display("FAIL b2b_count[%0d]: got %0d, expected 3", i, count);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'd0, 32'd0, 1);
      n_tests++;
      if (vec_rs1_data !== 32'h18 + i) begin
        n_fail++;
        $display("FAIL b2b_tail[%0d]: rs1=%h, expected %h", i, vec_rs1_data, 32'h18 + i);
      end
      step();
    end
    vec_ready = 0;
    n_tests++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_empty: empty=%b, expected 1", empty);
    end
  endtask

  task automatic test_drop();
    logic [31:0] seq [2];
    seq[0] = ADDI;
    seq[1] = FLW;
    for (int i = 0; i < 2; i++) begin
      drive(1, seq[i], 32'h0, 0);
      step();
      n_tests++;
      if (drop_pulse !== 1'b1 || count !== 3'd0) begin
        n_fail++;
        $display("FAIL drop_pulse[%0d]: drop=%b count=%0d, expected 1 0", i, drop_pulse, count);
      end
      drive(0, 32'd0, 32'd0, 0);
      step();
      n_tests++;
      if (drop_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL drop_one_cycle[%0d]: drop=%b, expected 0", i, drop_pulse);
      end
    end
    drive(1, VLE, 32'h77, 0);
    step();
    inst_valid = 0;
    n_tests++;
    if (count !== 3'd1 || drop_pulse !== 1'b0 || vec_instruction !== VLE) begin
      n_fail++;
      $display("FAIL drop_vle_stored: count=%0d drop=%b inst=%h, expected 1 0 %h",
               count, drop_pulse, vec_instruction, VLE);
    end
    drive(0, 32'd0, 32'd0, 1);
    step();
    vec_ready = 0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1, VADD, 32'h30 + i, 0);
      step();
    end
    @(negedge clk);
    flush       = 1;
    inst_valid  = 1;
    instruction = VADD;
    rs1_data    = 32'h3F;
    #1;
    n_tests++;
    if (inst_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: inst_ready=%b, expected 0", inst_ready);
    end
    step();
    n_tests++;
    if (count !== 3'd0 || empty !== 1'b1 || drop_pulse !== 1'b0 || vec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cleared: count=%0d empty=%b drop=%b vec_valid=%b, expected 0 1 0 0",
               count, empty, drop_pulse, vec_valid);
    end
    @(negedge clk);
    flush = 0;
    inst_valid = 0;
    step();
    n_tests++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_no_accept: count=%0d, expected 0", count);
    end
  endtask

  task automatic test_bypass();
    drive(1, VADD, 32'h55, 1);
`ifdef VEC_IQ_BYPASS_EN
    n_tests++;
    if (vec_valid !== 1'b1 || vec_rs1_data !== 32'h55) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: valid=%b rs1=%h, expected 1 00000055", vec_valid, vec_rs1_data);
    end
    step();
    inst_valid = 0;
    n_tests++;
    if (count !== 3'd0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_not_stored: count=%0d empty=%b, expected 0 1", count, empty);
    end
`else
    n_tests++;
    if (vec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL nobypass_same_cycle: valid=%b, expected 0", vec_valid);
    end
    step();
    inst_valid = 0;
    n_tests++;
    if (vec_valid !== 1'b1 || count !== 3'd1 || vec_rs1_data !== 32'h55) begin
      n_fail++;
      $display("FAIL nobypass_next_cycle: valid=%b count=%0d rs1=%h, expected 1 1 00000055",
               vec_valid, count, vec_rs1_data);
    end
    step();
    n_tests++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL nobypass_consumed: count=%0d, expected 0", count);
    end
`endif
    vec_ready = 0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, VADD, 32'h60 + i, 0);
      step();
    end
    inst_valid = 0;
    @(negedge clk);
    #2;
    reset = 0;
    #1;
    n_tests++;
    if (count !== 3'd0 || empty !== 1'b1 || vec_valid !== 1'b0 || vec_rs1_data !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: count=%0d empty=%b valid=%b rs1=%h, expected 0 1 0 0",
               count, empty, vec_valid, vec_rs1_data);
    end
    inst_valid = 1;
    instruction = VADD;
    step();
    n_tests++;
    if (inst_ready !== 1'b1 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_hold: inst_ready=%b count=%0d, expected 1 0", inst_ready, count);
    end
    @(negedge clk);
    inst_valid = 0;
    reset = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_drop();
    test_flush();
    test_bypass();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
